// File: rtl/encoder_event_fifo.sv
// rtl/encoder_event_fifo.sv - one-hot validator, 4-bit index encoder and event FIFO (option: ENCODER_EVENT_FIFO_ERRCNT_EN)
module encoder_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       encoder_in,
    output logic [3:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_multi,
    output logic              overflow,
    output logic [ADDR_W:0]   count
`ifdef ENCODER_EVENT_FIFO_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [3:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [3:0]        r_out_data;
    logic              r_err_multi;
    logic              r_overflow;

    logic              w_seen;
    logic              w_multi;
    logic [3:0]        w_index;
    logic              w_event;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_rd_next;
    logic [ADDR_W:0]   w_count_next;

    // Classify the request vector: any bit set, more than one bit set, and the set bit's index
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_index = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (encoder_in[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen  = 1'b1;
                w_index = 4'(i);
            end
        end
    end

    assign w_event   = enable & w_seen & ~w_multi;
    assign w_full    = (r_count == L_DEPTH);
    assign w_pop     = (r_count != '0) & out_ready;
    assign w_push    = w_event & (~w_full | w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

    // Occupancy after this edge: a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (ADDR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (ADDR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage array; contents need no reset because out_valid gates their use
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_index;
        end
    end

    // Pointers, occupancy, registered head, error pulse and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= 4'd0;
            r_err_multi <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_err_multi <= enable & w_multi;
            if (w_event & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
            // The head is registered so a fresh event shows one cycle later; when the
            // FIFO goes empty the last head value is simply held.
            if (w_count_next != '0) begin
                if (w_push && (r_wr_ptr == w_rd_next)) begin
                    r_out_data <= w_index;
                end else begin
                    r_out_data <= r_mem[w_rd_next];
                end
            end
        end
    end

`ifdef ENCODER_EVENT_FIFO_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating tally of multi-hot samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (enable && w_multi && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_count != '0);
    assign err_multi = r_err_multi;
    assign overflow  = r_overflow;
    assign count     = r_count;

endmodule
